// File: rtl/dct_block_loader.sv
// Ping-pong 8x8 block loader feeding the DCT row stage with 64-bit row vectors.
// Optional macro DCT_LEVEL_SHIFT_EN: emit pixel-128 (bit-7 inversion) instead of raw bytes.
module dct_block_loader #(
    parameter int PIX_W = 8,
    parameter int N     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic               dc_mode,
    output logic [N*PIX_W-1:0] row_data,
    output logic               row_valid,
    input  logic               row_ready,
    output logic [2:0]         row_idx,
    output logic               blk_last,
    output logic               control
);

    localparam int DEPTH = N * N;

    logic [PIX_W-1:0] mem [2][DEPTH];

    logic       wr_bank;
    logic       rd_bank;
    logic [5:0] wr_cnt;
    logic [2:0] rd_row;
    logic [1:0] full;
    logic [1:0] full_next;
    logic [1:0] mode;

    logic       accept;
    logic       xfer;
    logic       wr_last;
    logic       rd_last;
    logic [PIX_W-1:0] pix;

    assign pix_ready = rst_n && !full[wr_bank];
    assign accept    = pix_valid && pix_ready;
    assign wr_last   = (wr_cnt == 6'd63);

    assign row_valid = full[rd_bank];
    assign xfer      = row_valid && row_ready;
    assign rd_last   = (rd_row == 3'd7);

    assign row_idx   = rd_row;
    assign blk_last  = row_valid && rd_last;
    assign control   = row_valid ? mode[rd_bank] : 1'b0;

    // Fill and release always hit different banks, so both updates can apply in one cycle.
    always_comb begin
        full_next = full;
        if (accept && wr_last) full_next[wr_bank] = 1'b1;
        if (xfer && rd_last)   full_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_row  <= '0;
            full    <= '0;
            mode    <= '0;
        end else begin
            full <= full_next;
            if (accept) begin
                if (wr_cnt == 6'd0) mode[wr_bank] <= dc_mode;
                wr_cnt <= wr_cnt + 6'd1;
                if (wr_last) wr_bank <= ~wr_bank;
            end
            if (xfer) begin
                rd_row <= rd_row + 3'd1;
                if (rd_last) rd_bank <= ~rd_bank;
            end
        end
    end

    // Storage is deliberately left out of reset; stale bytes are never presented.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_bank][wr_cnt] <= pix_in;
    end

    always_comb begin
        row_data = '0;
        pix      = '0;
        for (int unsigned c = 0; c < N; c++) begin
            pix = mem[rd_bank][{rd_row, 3'(c)}];
`ifdef DCT_LEVEL_SHIFT_EN
            pix[PIX_W-1] = ~pix[PIX_W-1];
`endif
            row_data[(N-1-c)*PIX_W +: PIX_W] = pix;
        end
    end

endmodule

// File: tb/tb_dct_block_loader.sv
// Scoreboard bench for dct_block_loader: model pushes expected rows when a block completes.
module tb_dct_block_loader;

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  idx;
        logic        last;
        logic        ctrl;
    } row_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic        dc_mode;
    logic [63:0] row_data;
    logic        row_valid;
    logic        row_ready;
    logic [2:0]  row_idx;
    logic        blk_last;
    logic        control;

    dct_block_loader #(.PIX_W(8), .N(8)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .dc_mode(dc_mode), .row_data(row_data),
        .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx),
        .blk_last(blk_last), .control(control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    row_t       exp_q[$];
    logic [7:0] blk[64];
    int         mcnt, pending, mrd;
    logic       mmode;
    int         total, bad;

    logic        o_pready, o_rvalid, o_last, o_ctrl, exp_pready, acc, xfer;
    logic [63:0] o_data;
    logic [2:0]  o_idx;

    function automatic logic [7:0] ls(input logic [7:0] p);
`ifdef DCT_LEVEL_SHIFT_EN
        return p ^ 8'h80;
`else
        return p;
`endif
    endfunction

    // One clock: drive, sample combinational outputs, advance edge, update model.
    task automatic step(input logic pv, input logic [7:0] px, input logic dm, input logic rr);
        row_t r;
        pix_valid = pv; pix_in = px; dc_mode = dm; row_ready = rr;
        #1;
        o_pready = pix_ready; o_rvalid = row_valid; o_data = row_data;
        o_idx = row_idx; o_last = blk_last; o_ctrl = control;
        exp_pready = rst_n && (pending < 2);
        acc  = pv && o_pready;
        xfer = o_rvalid && rr;
        @(posedge clk); #1;
        if (!rst_n) begin
            mcnt = 0; pending = 0; mrd = 0; exp_q.delete();
        end else begin
            if (xfer) begin
                if (mrd == 7) begin mrd = 0; pending--; end
                else mrd++;
            end
            if (acc) begin
                blk[mcnt] = px;
                if (mcnt == 0) mmode = dm;
                if (mcnt == 63) begin
                    for (int j = 0; j < 8; j++) begin
                        r.data = '0;
                        for (int c = 0; c < 8; c++) r.data[(7-c)*8 +: 8] = ls(blk[j*8+c]);
                        r.idx = 3'(j); r.last = (j == 7); r.ctrl = mmode;
                        exp_q.push_back(r);
                    end
                    pending++;
                    mcnt = 0;
                end else mcnt++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(1'b1, 8'h55, 1'b1, 1'b1);
        step(1'b1, 8'h55, 1'b1, 1'b1);
        total += 5;
        if (o_pready !== 1'b0) begin bad++; $display("FAIL reset_pix_ready got=%b exp=0", o_pready); end
        if (o_rvalid !== 1'b0) begin bad++; $display("FAIL reset_row_valid got=%b exp=0", o_rvalid); end
        if (o_last !== 1'b0)   begin bad++; $display("FAIL reset_blk_last got=%b exp=0", o_last); end
        if (o_ctrl !== 1'b0)   begin bad++; $display("FAIL reset_control got=%b exp=0", o_ctrl); end
        if (o_idx !== 3'd0)    begin bad++; $display("FAIL reset_row_idx got=%0d exp=0", o_idx); end
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        total += 2;
        if (o_pready !== 1'b1) begin bad++; $display("FAIL release_pix_ready got=%b exp=1", o_pready); end
        if (o_rvalid !== 1'b0) begin bad++; $display("FAIL release_row_valid got=%b exp=0", o_rvalid); end
    endtask

    task automatic test_single_block;
        row_t e;
        int cyc, first, lastc;
        logic [63:0] c0;
`ifdef DCT_LEVEL_SHIFT_EN
        c0 = 64'h8081828384858687;
`else
        c0 = 64'h0001020304050607;
`endif
        cyc = 0; first = 0; lastc = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b1);
            cyc++;
            total++;
            if (o_pready !== 1'b1) begin bad++; $display("FAIL single_pix_ready i=%0d got=%b exp=1", i, o_pready); end
        end
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            cyc++;
            if (xfer) begin
                if (first == 0) first = cyc;
                lastc = cyc;
                e = exp_q.pop_front();
                total++;
                if ({o_data, o_idx, o_last, o_ctrl} !== e) begin
                    bad++; $display("FAIL single_row got=%h/%0d/%b/%b exp=%h/%0d/%b/%b",
                                    o_data, o_idx, o_last, o_ctrl, e.data, e.idx, e.last, e.ctrl);
                end
                if (o_idx == 3'd0) begin
                    total++;
                    if (o_data !== c0) begin bad++; $display("FAIL single_row0 got=%h exp=%h", o_data, c0); end
                end
            end
        end
        total += 3;
        if (first != 65) begin bad++; $display("FAIL single_first_cycle got=%0d exp=65", first); end
        if (lastc != 72) begin bad++; $display("FAIL single_last_cycle got=%0d exp=72", lastc); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL single_drain left=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        row_t e;
        int nrows;
        nrows = 0;
        for (int k = 0; k < 230; k++) begin
            if (k < 192) step(1'b1, 8'($urandom), (k / 64) != 1, 1'b1);
            else if (exp_q.size() > 0) step(1'b0, 8'h00, 1'b0, 1'b1);
            else break;
            if (k < 192) begin
                total++;
                if (o_pready !== 1'b1) begin bad++; $display("FAIL b2b_pix_ready k=%0d got=%b exp=1", k, o_pready); end
            end
            if (xfer) begin
                nrows++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_unexpected_row got=%h exp=none", o_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({o_data, o_idx, o_last, o_ctrl} !== e) begin
                        bad++; $display("FAIL b2b_row got=%h/%0d/%b/%b exp=%h/%0d/%b/%b",
                                        o_data, o_idx, o_last, o_ctrl, e.data, e.idx, e.last, e.ctrl);
                    end
                end
            end
        end
        total++;
        if (nrows != 24) begin bad++; $display("FAIL b2b_row_count got=%0d exp=24", nrows); end
    endtask

    task automatic test_backpressure;
        row_t e;
        int nacc, nrows;
        nacc = 0; nrows = 0;
        for (int k = 0; k < 140; k++) begin
            step(1'b1, 8'(nacc * 5 + 1), nacc >= 64, 1'b0);
            total++;
            if (o_pready !== exp_pready) begin bad++; $display("FAIL bp_pix_ready k=%0d got=%b exp=%b", k, o_pready, exp_pready); end
            if (acc) nacc++;
        end
        total += 2;
        if (nacc != 128) begin bad++; $display("FAIL bp_accepts got=%0d exp=128", nacc); end
        if (o_pready !== 1'b0) begin bad++; $display("FAIL bp_stalled got=%b exp=0", o_pready); end
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            if (xfer) begin
                nrows++;
                e = exp_q.pop_front();
                total++;
                if ({o_data, o_idx, o_last, o_ctrl} !== e) begin
                    bad++; $display("FAIL bp_row got=%h/%0d/%b/%b exp=%h/%0d/%b/%b",
                                    o_data, o_idx, o_last, o_ctrl, e.data, e.idx, e.last, e.ctrl);
                end
            end
        end
        total++;
        if (nrows != 16) begin bad++; $display("FAIL bp_row_count got=%0d exp=16", nrows); end
    endtask

    task automatic test_hold;
        row_t e;
        logic [63:0] held;
        for (int i = 0; i < 64; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            e = exp_q.pop_front();
            total++;
            if (!xfer || {o_data, o_idx, o_last, o_ctrl} !== e) begin
                bad++; $display("FAIL hold_pre_row got=%h/%0d xfer=%b exp=%h/%0d", o_data, o_idx, xfer, e.data, e.idx);
            end
        end
        held = exp_q[0].data;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            total += 3;
            if (o_rvalid !== 1'b1) begin bad++; $display("FAIL hold_valid k=%0d got=%b exp=1", k, o_rvalid); end
            if (o_idx !== 3'd3)    begin bad++; $display("FAIL hold_idx k=%0d got=%0d exp=3", k, o_idx); end
            if (o_data !== held)   begin bad++; $display("FAIL hold_data k=%0d got=%h exp=%h", k, o_data, held); end
        end
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            if (xfer) begin
                e = exp_q.pop_front();
                total++;
                if ({o_data, o_idx, o_last, o_ctrl} !== e) begin
                    bad++; $display("FAIL hold_row got=%h/%0d/%b/%b exp=%h/%0d/%b/%b",
                                    o_data, o_idx, o_last, o_ctrl, e.data, e.idx, e.last, e.ctrl);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL hold_drain left=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        row_t e;
        int nrows;
        nrows = 0;
        for (int i = 0; i < 100; i++) step(1'b1, 8'(i + 100), 1'b1, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        total += 2;
        if (o_rvalid !== 1'b0) begin bad++; $display("FAIL midrst_row_valid got=%b exp=0", o_rvalid); end
        if (o_pready !== 1'b1) begin bad++; $display("FAIL midrst_pix_ready got=%b exp=1", o_pready); end
        for (int k = 0; k < 90; k++) begin
            if (k < 64) step(1'b1, 8'(k * 3), 1'b0, 1'b1);
            else if (exp_q.size() > 0) step(1'b0, 8'h00, 1'b0, 1'b1);
            else break;
            if (xfer) begin
                nrows++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL midrst_unexpected_row got=%h exp=none", o_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({o_data, o_idx, o_last, o_ctrl} !== e) begin
                        bad++; $display("FAIL midrst_row got=%h/%0d/%b/%b exp=%h/%0d/%b/%b",
                                        o_data, o_idx, o_last, o_ctrl, e.data, e.idx, e.last, e.ctrl);
                    end
                end
            end
        end
        total++;
        if (nrows != 8) begin bad++; $display("FAIL midrst_row_count got=%0d exp=8", nrows); end
    endtask

    task automatic test_level_shift;
        row_t e;
        int nrows;
        logic [63:0] kff, k00, want;
`ifdef DCT_LEVEL_SHIFT_EN
        kff = 64'h7F7F7F7F7F7F7F7F; k00 = 64'h8080808080808080;
`else
        kff = 64'hFFFFFFFFFFFFFFFF; k00 = 64'h0000000000000000;
`endif
        nrows = 0;
        for (int k = 0; k < 160; k++) begin
            if (k < 128) step(1'b1, (k < 64) ? 8'hFF : 8'h00, 1'b1, 1'b1);
            else if (exp_q.size() > 0) step(1'b0, 8'h00, 1'b0, 1'b1);
            else break;
            if (xfer) begin
                want = (nrows < 8) ? kff : k00;
                nrows++;
                total += 2;
                if (o_data !== want) begin bad++; $display("FAIL shift_const got=%h exp=%h", o_data, want); end
                if (exp_q.size() == 0) begin bad++; $display("FAIL shift_unexpected_row got=%h exp=none", o_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({o_data, o_idx, o_last, o_ctrl} !== e) begin
                        bad++; $display("FAIL shift_row got=%h/%0d/%b/%b exp=%h/%0d/%b/%b",
                                        o_data, o_idx, o_last, o_ctrl, e.data, e.idx, e.last, e.ctrl);
                    end
                end
            end
        end
        total++;
        if (nrows != 16) begin bad++; $display("FAIL shift_row_count got=%0d exp=16", nrows); end
    endtask

    initial begin
        total = 0; bad = 0; mcnt = 0; pending = 0; mrd = 0; mmode = 1'b0;
        rst_n = 1'b0; pix_valid = 1'b0; pix_in = '0; dc_mode = 1'b0; row_ready = 1'b0;
        @(posedge clk); #1;
        test_reset;
        test_single_block;
        test_back_to_back;
        test_backpressure;
        test_hold;
        test_reset_mid;
        test_level_shift;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/dct_block_loader.md
# dct_block_loader

Upstream feeder for the combinational 8-point DCT row stage. Accepts an unsigned 8-bit pixel stream in raster order and assembles complete 8×8 blocks in a two-bank ping-pong buffer. Presents each block to the DCT as eight 64-bit row vectors under a valid/ready handshake, together with the per-block `control` (DC mode) bit. One bank fills while the other drains, so a continuous pixel stream is never stalled by a ready consumer.

## Interface
Parameters:
- `PIX_W`, 8: pixel width; only 8 is supported, matching the DCT `x` inputs.
- `N`, 8: block dimension; only 8 is supported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `pix_in`  in  8  unsigned pixel.
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_ready`  out  1  loader accepts `pix_in` this cycle.
- `dc_mode`  in  1  DC mode for the block being started; sampled with the block's first pixel.
- `row_data`  out  64  row vector; pixel 0 of the row in `[63:56]`, pixel 7 in `[7:0]`.
- `row_valid`  out  1  `row_data` is valid.
- `row_ready`  in  1  downstream consumes the row.
- `row_idx`  out  3  row number 0..7 within the block.
- `blk_last`  out  1  high with row 7.
- `control`  out  1  latched `dc_mode` of the draining block; drives the DCT `control` input.

## Operation
- Storage: two banks of 64 bytes each, with per-bank `full` flags and per-bank latched mode bits.
- Write side:
  - A pixel is accepted when `pix_valid && pix_ready`.
  - `pix_ready = rst_n && !full[wr_bank]`.
  - The accepted pixel is written to `wr_bank[wr_cnt]`. `wr_cnt` is 6 bits; row = `wr_cnt[5:3]`, column = `wr_cnt[2:0]`.
  - On acceptance with `wr_cnt==0`, `dc_mode` is latched into `mode[wr_bank]`.
  - On acceptance with `wr_cnt==63`: set `full[wr_bank]`, toggle `wr_bank`, and wrap `wr_cnt` to 0.
- Read side:
  - `row_valid = full[rd_bank]`.
  - `row_data` = row `rd_row` of `rd_bank`, level-shifted per Configuration.
  - A row transfers when `row_valid && row_ready`; `rd_row` then increments.
  - On transfer with `rd_row==7`: clear `full[rd_bank]`, toggle `rd_bank`, set `rd_row` to 0.
- `row_idx = rd_row`. `blk_last = row_valid && rd_row==7`. `control = row_valid ? mode[rd_bank] : 0`.
- Outputs are held stable while `row_valid && !row_ready`.
- Simultaneous events:
  - Same-cycle completion of a write bank and release of the read bank both take effect.
  - Completion of a write bank while the other bank is full: `pix_ready` drops the next cycle.
  - Release of a bank makes that bank writable the next cycle.
- Pixels presented while `pix_ready=0` are not consumed; the source holds them.
- Reset (mid-operation included) discards all partial and complete blocks. Buffer contents are not cleared.

## Timing
- Reset values: `wr_bank=0`, `rd_bank=0`, `wr_cnt=0`, `rd_row=0`, `full=2'b00`, `mode=2'b00`. Resulting outputs: `row_valid=0`, `blk_last=0`, `control=0`, `row_idx=0`. `pix_ready=0` while `rst_n=0` and 1 on the first cycle after release.
- Latency: `row_valid` rises the cycle after the 64th pixel of a block is accepted.
- Output path: `row_data` is a combinational mux from registered storage; there is no pipeline register on the output.
- Throughput: 1 pixel per cycle sustained with a ready consumer. A block drains in 8 cycles when `row_ready` is held high.
- Backpressure: with `row_ready=0`, the loader accepts at most 128 pixels (both banks) before stalling.

## Configuration
- `DCT_LEVEL_SHIFT_EN`
  - Defined: each byte of `row_data` is `pixel - 128`, implemented as inversion of bit 7. Two's-complement signed range is −128..127.
  - Undefined: bytes pass through unchanged.
- The storage and the handshake behaviour are identical in both builds.

## Test plan
- Reset, then 64 pixels 0..63 with `dc_mode=1` and `row_ready=1`:
  - Rows appear on cycles 65..72.
  - Row 0 is `64'h0001020304050607`; with the macro it is `64'h8081828384858687`.
  - `control=1` on all rows; `blk_last` only with row 7.
- Continuous stream of 192 pixels with `row_ready=1`: `pix_ready` never drops; three blocks are emitted in order with the correct `mode` per block.
- `row_ready=0` throughout: `pix_ready` drops after exactly 128 accepts. Then `row_ready=1`: 16 rows drain, block A before block B.
- Hold `row_ready=0` mid-block at row 3 for 5 cycles: `row_data` and `row_idx=3` stay stable; no row is skipped.
- Assert `rst_n=0` for 1 cycle after 100 accepted pixels: `row_valid=0` and `full=0` next cycle. The next 64 pixels form a clean block starting at row 0.
- All pixels `8'hFF` with the macro defined: every row is `64'h7F7F7F7F7F7F7F7F`. All pixels `8'h00`: every row is `64'h8080808080808080`.
